// File: rtl/instr_fetch.sv
// RV64 instruction-fetch stage: PC, imem req/ack handshake, redirect/drain and IF/ID flush.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_write,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [63:0] PC_out,
  output logic [31:0] Instruction,
  output logic        fetch_valid,
  output logic        flush,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, VALID, DRAIN, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, VALID, DRAIN} state_t;
`endif

  state_t      state;
  logic [63:0] pc, req_addr, tgt, pc_next;

  assign tgt       = branch_target & ~64'h3;
  assign pc_next   = pc + 64'd4;
  assign imem_addr = req_addr;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] to_cnt;
  logic          to_hit;

  // Zero whenever a request is (re)started or completes, so it only counts a stuck wait.
  always_ff @(posedge clk) begin
    if (reset || imem_ack || branch_taken || (state != REQ && state != DRAIN))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit    = (to_cnt == CW'(TIMEOUT_CYCLES - 1)) && !imem_ack && !branch_taken;
  assign fetch_err = (state == ERR);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign fetch_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      PC_out      <= '0;
      Instruction <= '0;
      fetch_valid <= 1'b0;
      imem_req    <= 1'b0;
      flush       <= 1'b0;
    end else begin
      flush <= branch_taken;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (branch_taken) begin
            pc       <= tgt;
            req_addr <= tgt;
          end else begin
            req_addr <= pc;
          end
        end
        REQ: begin
          if (branch_taken) begin
            pc          <= tgt;
            fetch_valid <= 1'b0;
            // Without ack the old request must still complete, so park it in DRAIN.
            if (imem_ack) req_addr <= tgt;
            else          state    <= DRAIN;
          end else if (imem_ack) begin
            Instruction <= imem_rdata;
            PC_out      <= req_addr;
            fetch_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= VALID;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (to_hit) begin
            imem_req <= 1'b0;
            state    <= ERR;
          end
`endif
        end
        VALID: begin
          if (branch_taken) begin
            pc          <= tgt;
            req_addr    <= tgt;
            fetch_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end else if (PC_write) begin
            pc          <= pc_next;
            req_addr    <= pc_next;
            fetch_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            // Stale word dropped; restart at the newest redirect target.
            req_addr <= branch_taken ? tgt : pc;
            if (branch_taken) pc <= tgt;
            state <= REQ;
          end else if (branch_taken) begin
            pc <= tgt;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (to_hit) begin
            imem_req <= 1'b0;
            state    <= ERR;
          end
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        ERR: begin
          imem_req    <= 1'b0;
          fetch_valid <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: scoreboard of presented fetches plus cycle checks.
module tb_instr_fetch;
  logic        clk = 1'b0, reset = 1'b1, PC_write = 1'b1, branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        imem_req, imem_ack = 1'b0;
  logic [63:0] imem_addr, PC_out;
  logic [31:0] imem_rdata = '0, Instruction;
  logic        fetch_valid, flush, fetch_err;

  instr_fetch #(.RESET_PC(64'h1000), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .PC_write(PC_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_out(PC_out),
    .Instruction(Instruction), .fetch_valid(fetch_valid), .flush(flush),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] pc; logic [31:0] ins; } fetch_t;
  fetch_t      exp_q[$];
  fetch_t      sb_e;
  int          npass = 0, ntotal = 0;
  int          ack_delay = 0, wait_cnt = 0;
  bit          mem_on = 1'b1, use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;
  logic [63:0] wrap_pc = 64'hFFFF_FFFF_FFFF_FFFC;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic fetch_t mk(input logic [63:0] a);
    fetch_t f;
    f.pc  = a;
    f.ins = mem_word(a);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory model: acks after ack_delay extra request cycles.
  always @(negedge clk) begin
    #1;
    imem_ack = 1'b0;
    if (mem_on && imem_req && !reset) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = use_fixed ? fixed_data : mem_word(imem_addr);
        wait_cnt   = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  // Scoreboard on each newly presented instruction, plus request address stability.
  logic        prev_fv = 1'b0, prev_req = 1'b0;
  logic [63:0] prev_addr = '0;
  always @(negedge clk) begin
    if (fetch_valid && !prev_fv) begin
      if (exp_q.size() == 0) begin
        ntotal++;
        $error("FAIL sb_unexpected: observed pc %h expected no fetch", PC_out);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_pc", PC_out, sb_e.pc);
        chk("sb_instr", 64'(Instruction), 64'(sb_e.ins));
      end
    end
    if (prev_req && imem_req && !imem_ack && !reset)
      chk("addr_stable", imem_addr, prev_addr);
    prev_fv   = fetch_valid;
    prev_req  = imem_req;
    prev_addr = imem_addr;
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'(0));
    chk("rst_fv", 64'(fetch_valid), 64'(0));
    chk("rst_pc_out", PC_out, 64'h0);
    chk("rst_instr", 64'(Instruction), 64'h0);
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_err", 64'(fetch_err), 64'(0));
    chk("rst_addr", imem_addr, 64'h1000);
    exp_q.push_back(mk(64'h1000));
    exp_q.push_back(mk(64'h1004));
    exp_q.push_back(mk(64'h1008));
    reset = 1'b0;

    @(negedge clk);
    chk("first_req", 64'(imem_req), 64'(1));
    chk("first_addr", imem_addr, 64'h1000);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      chk("fv_stream", 64'(fetch_valid), 64'(i % 2 == 0));
      chk("no_flush", 64'(flush), 64'(0));
    end

    PC_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", PC_out, 64'h1008);
      chk("stall_instr", 64'(Instruction), 64'(mem_word(64'h1008)));
      chk("stall_fv", 64'(fetch_valid), 64'(1));
      chk("stall_req", 64'(imem_req), 64'(0));
    end
    PC_write = 1'b1;
    exp_q.push_back(mk(64'h100C));
    @(negedge clk);
    chk("resume_req", 64'(imem_req), 64'(1));
    chk("resume_addr", imem_addr, 64'h100C);

    @(negedge clk);
    branch_taken = 1'b1; branch_target = 64'h2002;
    exp_q.push_back(mk(64'h2000));
    @(negedge clk);
    chk("br_flush", 64'(flush), 64'(1));
    chk("br_addr", imem_addr, 64'h2000);
    chk("br_fv", 64'(fetch_valid), 64'(0));
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br_flush_1cyc", 64'(flush), 64'(0));
    ack_delay = 3;

    @(negedge clk);
    chk("slow_addr", imem_addr, 64'h2004);
    branch_taken = 1'b1; branch_target = 64'h3000;
    @(negedge clk);
    chk("drain_flush", 64'(flush), 64'(1));
    chk("drain_req", 64'(imem_req), 64'(1));
    chk("drain_addr", imem_addr, 64'h2004);
    branch_taken = 1'b0; use_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
    exp_q.push_back(mk(64'h3000));
    @(negedge clk);
    chk("drain_flush_1cyc", 64'(flush), 64'(0));
    @(negedge clk);
    chk("drain_hold_addr", imem_addr, 64'h2004);
    @(negedge clk);
    chk("redir_req", 64'(imem_req), 64'(1));
    chk("redir_addr", imem_addr, 64'h3000);
    chk("redir_fv", 64'(fetch_valid), 64'(0));
    ack_delay = 0; use_fixed = 1'b0;

    @(negedge clk);
    chk("redir_fv_set", 64'(fetch_valid), 64'(1));
    branch_taken = 1'b1; branch_target = wrap_pc;
    exp_q.push_back(mk(wrap_pc));
    @(negedge clk);
    chk("wrap_br_addr", imem_addr, wrap_pc);
    branch_taken = 1'b0;
    exp_q.push_back(mk(64'h0));
    @(negedge clk);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 64'h0);
    @(negedge clk);
    ack_delay = 5;
    @(negedge clk);
    chk("pre_rst_addr", imem_addr, 64'h4);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req", 64'(imem_req), 64'(0));
    chk("midrst_fv", 64'(fetch_valid), 64'(0));
    chk("midrst_addr", imem_addr, 64'h1000);

    mem_on = 1'b0;
    reset  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("to_wait_req", 64'(imem_req), 64'(1));
      chk("to_wait_err", 64'(fetch_err), 64'(0));
    end
    @(negedge clk);
    chk("to_err", 64'(fetch_err), 64'(1));
    chk("to_req", 64'(imem_req), 64'(0));
    chk("to_fv", 64'(fetch_valid), 64'(0));
    branch_taken = 1'b1;
    repeat (3) @(negedge clk);
    chk("to_sticky", 64'(fetch_err), 64'(1));
    chk("to_sticky_req", 64'(imem_req), 64'(0));
    branch_taken = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("to_cleared", 64'(fetch_err), 64'(0));
    reset = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("wait_req", 64'(imem_req), 64'(1));
      chk("wait_addr", imem_addr, 64'h1000);
      chk("wait_err", 64'(fetch_err), 64'(0));
    end
`endif
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
